appr_mul_accum: RTL and testbench
=================================

APPR_MUL_ACCUM -- requirements
Module: appr_mul_accum

Interface
REQ-001 Parameter ACC_W, default 40: accumulator and result width in bits; legal range 33..64.
REQ-002 Parameter CNT_W, default 16: beat-counter width in bits.
REQ-003 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  product beat valid.
REQ-007 in_ready  output  1  block can accept a product beat.
REQ-008 in_prod  input  32  signed two's-complement product from the upstream approximate 16x16 multiplier.
REQ-009 in_last  input  1  final beat of the current frame; qualified by in_valid.
REQ-010 flush  input  1  abort the current frame and discard any held result.
REQ-011 out_valid  output  1  frame result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_acc  output  ACC_W  signed sum of the frame's products.
REQ-014 out_cnt  output  CNT_W  number of beats in the frame.
REQ-015 out_ovf  output  1  sticky signed-overflow flag for the frame.

Function
REQ-016 A beat SHALL be accepted only in a cycle where in_valid=1, in_ready=1 and flush=0.
REQ-017 The FSM SHALL have three states: IDLE, ACC and HOLD.
REQ-018 In IDLE and ACC, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-019 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-020 A beat accepted in IDLE SHALL load acc to sext(in_prod), load cnt to 1 and clear ovf.
REQ-021 A beat accepted in ACC SHALL update acc to acc + sext(in_prod) as an ACC_W-bit two's-complement sum with wrap.
REQ-022 A beat accepted in ACC SHALL increment cnt, saturating at all-ones.
REQ-023 A beat accepted in ACC SHALL set ovf if the signed add overflows; ovf SHALL remain set until the next frame starts.
REQ-024 Transitions on an accepted beat: IDLE with in_last=0 goes to ACC; IDLE or ACC with in_last=1 goes to HOLD; ACC with in_last=0 stays in ACC.
REQ-025 out_valid SHALL rise in the cycle after the last beat is accepted (latency 1 cycle).
REQ-026 out_acc, out_cnt and out_ovf SHALL be driven directly from acc, cnt and ovf.
REQ-027 Result outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-028 In HOLD, out_ready=1 SHALL return the FSM to IDLE at the next edge.
REQ-029 No beat SHALL be accepted in the HOLD exit cycle, so there is exactly one bubble between frames.
REQ-030 flush=1 in any state SHALL force IDLE at the next edge without producing a result.
REQ-031 flush=1 SHALL clear acc, cnt and ovf.
REQ-032 flush=1 SHALL take priority over a simultaneous beat; that beat is dropped.
REQ-033 flush=1 SHALL take priority over a simultaneous out_ready; the held result is discarded.
REQ-034 in_valid=0 in ACC SHALL hold all state; there is no timeout.
REQ-035 in_last while in_valid=0 SHALL be ignored.
REQ-036 in_prod and in_last SHALL be sampled only on an accepted beat.

Reset
REQ-037 While rst_n=0 at an edge: state=IDLE, acc=0, cnt=0, ovf=0.
REQ-038 Consequently, after reset in_ready=1, out_valid=0, out_acc=0, out_cnt=0 and out_ovf=0.
REQ-039 Reset asserted mid-frame or in HOLD SHALL discard all state with no result emitted.
REQ-040 Reset SHALL take priority over flush and over any handshake.

Verification
REQ-041 Single-beat frame: beat 0x00000064 with in_last=1 -> next cycle out_valid=1, out_acc=100, out_cnt=1, out_ovf=0.
REQ-042 Mixed-sign frame: beats 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF (last) -> out_acc=-2 (ACC_W=40), out_cnt=3, out_ovf=0.
REQ-043 Overflow frame: ACC_W=33, beats 0x7FFFFFFF x3 (last on the third) -> out_ovf=1, out_acc wrapped, out_cnt=3.
REQ-044 Backpressure: hold out_ready=0 for 5 cycles in HOLD -> outputs constant and in_ready=0 throughout; out_ready=1 -> IDLE the next cycle, in_ready=1.
REQ-045 Flush: flush=1 together with the last beat of a 4-beat frame -> no out_valid; next frame's single beat 5 yields out_acc=5, out_cnt=1.
REQ-046 Reset mid-frame: after 2 accepted beats, drive rst_n=0 for 1 cycle -> all outputs 0, in_ready=1, no result for the aborted frame.

Source files
------------

// File: rtl/appr_mul_accum.sv
// Frame accumulator for signed 32-bit products from an approximate multiplier.
// Sums one frame of beats, counts them, flags signed overflow, and holds the result until taken.
module appr_mul_accum #(
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic [1:0]       fsm_state
);

    // Handshake: a beat transfers when in_valid && in_ready && !flush at a rising edge;
    // a result transfers when out_valid && out_ready && !flush at a rising edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             sum_ovf;

    assign prod_ext = {{(ACC_W-32){in_prod[31]}}, in_prod};
    assign sum      = acc + prod_ext;
    // Overflow when both operands share a sign that the wrapped sum does not.
    assign sum_ovf  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_next = in_last ? HOLD : ACC;
            end
            ACC: begin
                in_ready = 1'b1;
                if (accept && in_last) state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (state == IDLE) begin
                    acc <= prod_ext;
                    cnt <= CNT_W'(1);
                    ovf <= 1'b0;
                end else begin
                    acc <= sum;
                    if (cnt != {CNT_W{1'b1}}) cnt <= cnt + CNT_W'(1);
                    if (sum_ovf) ovf <= 1'b1;
                end
            end
        end
    end

    assign out_acc   = acc;
    assign out_cnt   = cnt;
    assign out_ovf   = ovf;
    assign fsm_state = state;

endmodule

// File: tb/tb_appr_mul_accum.sv
// Directed bench for appr_mul_accum: two instances (ACC_W=40 and ACC_W=33) share stimulus.
module tb_appr_mul_accum;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_prod;
    logic        in_last;
    logic        flush;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, out_ovf_a;
    logic [39:0] out_acc_a;
    logic [15:0] out_cnt_a;
    logic [1:0]  fsm_state_a;

    logic        in_ready_b, out_valid_b, out_ovf_b;
    logic [32:0] out_acc_b;
    logic [15:0] out_cnt_b;
    logic [1:0]  fsm_state_b;

    int n_cmp = 0;
    int n_err = 0;

    appr_mul_accum #(.ACC_W(40), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_prod(in_prod), .in_last(in_last), .flush(flush), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_acc(out_acc_a), .out_cnt(out_cnt_a),
        .out_ovf(out_ovf_a), .fsm_state(fsm_state_a)
    );

    appr_mul_accum #(.ACC_W(33), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_prod(in_prod), .in_last(in_last), .flush(flush), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_acc(out_acc_b), .out_cnt(out_cnt_b),
        .out_ovf(out_ovf_b), .fsm_state(fsm_state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic beat(input logic [31:0] prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_prod  = 32'hDEAD_BEEF;
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    logic [39:0] held_acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_in_ready", in_ready_a, 1);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_acc", out_acc_a, 0);
        chk("rst_cnt", out_cnt_a, 0);
        chk("rst_ovf", out_ovf_a, 0);
        chk("rst_state", fsm_state_a, 0);

        // Single-beat frame, result one cycle after the last beat
        beat(32'h0000_0064, 1'b1);
        chk("single_valid", out_valid_a, 1);
        chk("single_acc", out_acc_a, 100);
        chk("single_cnt", out_cnt_a, 1);
        chk("single_ovf", out_ovf_a, 0);
        chk("single_in_ready", in_ready_a, 0);

        // HOLD exit with a beat offered: the beat must be dropped
        in_valid = 1'b1; in_prod = 32'd7; in_last = 1'b1;
        take_result();
        in_valid = 1'b0; in_last = 1'b0;
        chk("exit_valid", out_valid_a, 0);
        chk("exit_in_ready", in_ready_a, 1);
        chk("exit_no_beat_acc", out_acc_a, 100);
        chk("exit_no_beat_cnt", out_cnt_a, 1);

        // Mixed-sign frame: 0x7FFFFFFF + (-2^31) + (-1) = -2
        beat(32'h7FFF_FFFF, 1'b0);
        chk("mixed_state_acc", fsm_state_a, 1);
        chk("mixed_mid_valid", out_valid_a, 0);
        beat(32'h8000_0000, 1'b0);
        beat(32'hFFFF_FFFF, 1'b1);
        chk("mixed_valid", out_valid_a, 1);
        chk("mixed_acc40", out_acc_a, 40'hFF_FFFF_FFFE);
        chk("mixed_acc33", out_acc_b, 33'h1_FFFF_FFFE);
        chk("mixed_cnt", out_cnt_a, 3);
        chk("mixed_ovf40", out_ovf_a, 0);
        chk("mixed_ovf33", out_ovf_b, 0);

        // Backpressure for 5 cycles, with a beat offered throughout
        held_acc = out_acc_a;
        in_valid = 1'b1; in_prod = 32'd55; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", out_valid_a, 1);
            chk("bp_in_ready", in_ready_a, 0);
            chk("bp_acc", out_acc_a, held_acc);
            chk("bp_cnt", out_cnt_a, 3);
        end
        in_valid = 1'b0;
        take_result();
        chk("bp_release_valid", out_valid_a, 0);
        chk("bp_release_in_ready", in_ready_a, 1);
        chk("bp_release_state", fsm_state_a, 0);

        // Overflow frame, with an idle gap carrying a stray in_last mid-frame
        beat(32'h7FFF_FFFF, 1'b0);
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        chk("gap_state", fsm_state_a, 1);
        chk("gap_cnt", out_cnt_a, 1);
        chk("gap_valid", out_valid_a, 0);
        beat(32'h7FFF_FFFF, 1'b0);
        chk("ovf_two_beats_ovf33", out_ovf_b, 0);
        beat(32'h7FFF_FFFF, 1'b1);
        chk("ovf_valid", out_valid_b, 1);
        chk("ovf_flag33", out_ovf_b, 1);
        chk("ovf_acc33", out_acc_b, 33'h1_7FFF_FFFD);
        chk("ovf_cnt33", out_cnt_b, 3);
        chk("ovf_flag40", out_ovf_a, 0);
        chk("ovf_acc40", out_acc_a, 40'h01_7FFF_FFFD);
        take_result();

        // Next frame clears the sticky flag
        beat(32'h0000_0001, 1'b1);
        chk("ovf_cleared33", out_ovf_b, 0);
        chk("ovf_cleared_acc33", out_acc_b, 1);
        take_result();

        // Flush together with the last beat of a 4-beat frame
        beat(32'd1, 1'b0);
        beat(32'd2, 1'b0);
        beat(32'd3, 1'b0);
        flush = 1'b1;
        beat(32'd4, 1'b1);
        flush = 1'b0;
        chk("flush_valid", out_valid_a, 0);
        chk("flush_acc", out_acc_a, 0);
        chk("flush_cnt", out_cnt_a, 0);
        chk("flush_in_ready", in_ready_a, 1);
        step();
        chk("flush_still_idle", out_valid_a, 0);
        beat(32'd5, 1'b1);
        chk("after_flush_valid", out_valid_a, 1);
        chk("after_flush_acc", out_acc_a, 5);
        chk("after_flush_cnt", out_cnt_a, 1);

        // Flush in HOLD beats out_ready: result discarded
        flush = 1'b1;
        take_result();
        flush = 1'b0;
        chk("flush_hold_valid", out_valid_a, 0);
        chk("flush_hold_acc", out_acc_a, 0);
        chk("flush_hold_cnt", out_cnt_a, 0);

        // Reset mid-frame after two beats, with a beat and flush presented during reset
        beat(32'd9, 1'b0);
        beat(32'd11, 1'b0);
        chk("pre_reset_acc", out_acc_a, 20);
        rst_n = 1'b0; in_valid = 1'b1; in_prod = 32'd3; in_last = 1'b1; flush = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0;
        chk("midrst_acc", out_acc_a, 0);
        chk("midrst_cnt", out_cnt_a, 0);
        chk("midrst_ovf", out_ovf_a, 0);
        chk("midrst_valid", out_valid_a, 0);
        chk("midrst_in_ready", in_ready_a, 1);
        step();
        chk("midrst_no_result", out_valid_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
